// File: rtl/hilo_md_unit.sv
// hilo_md_unit: multi-cycle multiply/divide unit that owns the HI/LO registers.
// Sits in the E stage beside the ALU. It runs mult/multu/div/divu over a fixed
// latency, serves mfhi/mflo/mthi/mtlo, and asks the hazard unit to stall any
// HI/LO instruction in D while an operation is starting or in flight.
// Optional build macro MDU_MADD_EN enables code 9 (madd: {HI,LO} += rs*rt, signed).
module hilo_md_unit #(
    parameter int MULT_LAT = 5,   // busy cycles for mult/multu/madd (1..15)
    parameter int DIV_LAT  = 10   // busy cycles for div/divu (1..15)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        eValid,
    input  logic [4:0]  hiloCtrl,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic        dUsesHilo,
    output logic        start,
    output logic        busy,
    output logic        stallReq,
    output logic [31:0] hiOut,
    output logic [31:0] loOut,
    output logic [31:0] mdResult
);

    localparam logic [4:0] C_MULTU = 5'd1;
    localparam logic [4:0] C_MULT  = 5'd2;
    localparam logic [4:0] C_DIVU  = 5'd3;
    localparam logic [4:0] C_DIV   = 5'd4;
    localparam logic [4:0] C_MFHI  = 5'd5;
    localparam logic [4:0] C_MFLO  = 5'd6;
    localparam logic [4:0] C_MTHI  = 5'd7;
    localparam logic [4:0] C_MTLO  = 5'd8;
    localparam logic [4:0] C_MADD  = 5'd9;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t      r_state;
    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_md;
    logic        w_is_mul_lat;
    logic [63:0] w_prod_u;
    logic [63:0] w_prod_s;
    logic [63:0] w_acc;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [31:0] w_div_u_den;
    logic [31:0] w_div_s_den;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic        w_write;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;

    // Classify the E-stage code: which codes launch an operation and which latency they use.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        w_is_md      = 1'b0;
        w_is_mul_lat = 1'b0;
        case (hiloCtrl)
            C_MULTU, C_MULT: begin
                w_is_md      = 1'b1;
                w_is_mul_lat = 1'b1;
            end
            C_DIVU, C_DIV: w_is_md = 1'b1;
`ifdef MDU_MADD_EN
            C_MADD: begin
                w_is_md      = 1'b1;
                w_is_mul_lat = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    assign start    = eValid & w_is_md & ~r_busy;
    assign busy     = r_busy;
    assign stallReq = (start | r_busy) & dUsesHilo;
    assign hiOut    = r_hi;
    assign loOut    = r_lo;

    // mfhi/mflo read port: purely combinational, no side effects.
    always_comb begin
        mdResult = 32'd0;
        if (hiloCtrl == C_MFHI) mdResult = r_hi;
        else if (hiloCtrl == C_MFLO) mdResult = r_lo;
    end

    // Result datapath from the latched operands; only sampled on the completion edge.
    always_comb begin
        w_prod_u    = {32'd0, r_a} * {32'd0, r_b};
        // Low 64 bits of the product of sign-extended operands is the signed product.
        w_prod_s    = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
        w_acc       = {r_hi, r_lo} + w_prod_s;
        // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
        w_mag_a     = r_a[31] ? (~r_a + 32'd1) : r_a;
        w_mag_b     = r_b[31] ? (~r_b + 32'd1) : r_b;
        // A zero divisor is replaced by 1 only to keep the divider defined; the result is discarded.
        w_div_u_den = (r_b == 32'd0) ? 32'd1 : r_b;
        w_div_s_den = (w_mag_b == 32'd0) ? 32'd1 : w_mag_b;
        w_q_mag     = w_mag_a / w_div_s_den;
        w_r_mag     = w_mag_a % w_div_s_den;
        w_write     = 1'b1;
        w_res_hi    = r_hi;
        w_res_lo    = r_lo;
        case (r_op)
            C_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
            C_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
            C_DIVU: begin
                w_write  = (r_b != 32'd0);
                w_res_lo = r_a / w_div_u_den;
                w_res_hi = r_a % w_div_u_den;
            end
            C_DIV: begin
                w_write  = (r_b != 32'd0);
                w_res_lo = (r_a[31] ^ r_b[31]) ? (~w_q_mag + 32'd1) : w_q_mag;
                w_res_hi = r_a[31] ? (~w_r_mag + 32'd1) : w_r_mag;
            end
            C_MADD: {w_res_hi, w_res_lo} = w_acc;
            default: w_write = 1'b0;
        endcase
    end

    // Control FSM plus HI/LO ownership: launch, count down, commit; mthi/mtlo while idle.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_cnt   <= 4'd0;
            r_op    <= 5'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= hiloCtrl;
                        r_a     <= opA;
                        r_b     <= opB;
                        r_cnt   <= w_is_mul_lat ? MULT_CNT : DIV_CNT;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end else if (eValid && hiloCtrl == C_MTHI) begin
                        r_hi <= opA;
                    end else if (eValid && hiloCtrl == C_MTLO) begin
                        r_lo <= opA;
                    end
                end
                S_RUN: begin
                    // Anything presented in E while running is a protocol violation and is ignored.
                    if (r_cnt == 4'd1) begin
                        if (w_write) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                        r_cnt   <= 4'd0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_md_unit.sv
// Self-checking bench for hilo_md_unit: directed cases plus random operations
// checked against an arithmetic model of HI/LO kept here.
module tb_hilo_md_unit;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        eValid;
    logic [4:0]  hiloCtrl;
    logic [31:0] opA;
    logic [31:0] opB;
    logic        dUsesHilo;
    logic        start;
    logic        busy;
    logic        stallReq;
    logic [31:0] hiOut;
    logic [31:0] loOut;
    logic [31:0] mdResult;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    hilo_md_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .eValid(eValid), .hiloCtrl(hiloCtrl),
        .opA(opA), .opB(opB), .dUsesHilo(dUsesHilo), .start(start),
        .busy(busy), .stallReq(stallReq), .hiOut(hiOut), .loOut(loOut),
        .mdResult(mdResult)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after a falling edge, away from the active edge.
    task automatic drive(input logic ev, input logic [4:0] code,
                         input logic [31:0] a, input logic [31:0] b, input logic du);
        @(negedge clk);
        eValid = ev; hiloCtrl = code; opA = a; opB = b; dUsesHilo = du;
        #1;
    endtask

    // Architectural effect of one operation on HI/LO, from the instruction definitions.
    task automatic model_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb, q, r, p;
        longint unsigned ua, ub, up;
        logic [63:0]     acc;
        sa = longint'($signed(a)); sb = longint'($signed(b));
        ua = longint'(a);          ub = longint'(b);
        case (code)
            5'd1: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
            5'd2: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
            5'd3: if (b != 0) begin
                up = ua / ub; m_lo = up[31:0];
                up = ua % ub; m_hi = up[31:0];
            end
            5'd4: if (b != 0) begin
                q = sa / sb; r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            5'd9: begin acc = {m_hi, m_lo} + 64'(sa * sb); m_hi = acc[63:32]; m_lo = acc[31:0]; end
            default: ;
        endcase
    endtask

    // Launch one mult/div-class op and follow it to completion.
    task automatic do_op(input logic [4:0] code, input logic [31:0] a, input logic [31:0] b, input logic du);
        int lat;
        logic [31:0] old_hi, old_lo;
        lat = (code == 5'd3 || code == 5'd4) ? DIV_LAT : MULT_LAT;
        old_hi = m_hi; old_lo = m_lo;
        drive(1'b1, code, a, b, du);
        chk("start_hi", {31'd0, start}, 32'd1);
        chk("busy_before", {31'd0, busy}, 32'd0);
        chk("stall_start", {31'd0, stallReq}, {31'd0, du});
        @(posedge clk); #1;
        // Operands change after the start edge; they must not matter.
        eValid = 1'b0; hiloCtrl = 5'd0; opA = $urandom; opB = $urandom;
        #1;
        for (int i = 0; i < lat; i++) begin
            chk("busy_run", {31'd0, busy}, 32'd1);
            chk("start_run", {31'd0, start}, 32'd0);
            chk("stall_run", {31'd0, stallReq}, {31'd0, du});
            chk("hi_hold", hiOut, old_hi);
            chk("lo_hold", loOut, old_lo);
            @(posedge clk); #2;
        end
        model_op(code, a, b);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("stall_done", {31'd0, stallReq}, 32'd0);
        chk("hi_result", hiOut, m_hi);
        chk("lo_result", loOut, m_lo);
        eValid = 1'b1; hiloCtrl = 5'd5; #1;
        chk("mfhi_after", mdResult, m_hi);
        hiloCtrl = 5'd6; #1;
        chk("mflo_after", mdResult, m_lo);
        eValid = 1'b0; hiloCtrl = 5'd0; dUsesHilo = 1'b0;
    endtask

    // mthi (7) / mtlo (8): single-edge write, never busy.
    task automatic do_mt(input logic [4:0] code, input logic [31:0] v);
        drive(1'b1, code, v, $urandom, 1'b0);
        chk("mt_start", {31'd0, start}, 32'd0);
        @(posedge clk); #1;
        eValid = 1'b0; hiloCtrl = 5'd0;
        if (code == 5'd7) m_hi = v; else m_lo = v;
        chk("mt_busy", {31'd0, busy}, 32'd0);
        chk("mt_hi", hiOut, m_hi);
        chk("mt_lo", loOut, m_lo);
    endtask

    initial begin
        logic [4:0]  rc;
        logic [31:0] ra, rb;
        reset = 1'b1; eValid = 1'b0; hiloCtrl = 5'd0; opA = 32'd0; opB = 32'd0; dUsesHilo = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hiOut, 32'd0);
        chk("rst_lo", loOut, 32'd0);
        @(negedge clk); reset = 1'b0;

        // Directed arithmetic cases
        do_op(5'd2, 32'hFFFF_FFFD, 32'd7, 1'b1);
        chk("mult_hi", hiOut, 32'hFFFF_FFFF);
        chk("mult_lo", loOut, 32'hFFFF_FFEB);
        do_op(5'd3, 32'd100, 32'd7, 1'b0);
        chk("divu_lo", loOut, 32'd14);
        chk("divu_hi", hiOut, 32'd2);
        do_op(5'd4, 32'hFFFF_FFF9, 32'd2, 1'b0);
        chk("div_lo", loOut, 32'hFFFF_FFFD);
        chk("div_hi", hiOut, 32'hFFFF_FFFF);
        do_op(5'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        chk("ovf_lo", loOut, 32'h8000_0000);
        chk("ovf_hi", hiOut, 32'd0);
        do_mt(5'd7, 32'h11);
        do_mt(5'd8, 32'h22);
        do_op(5'd4, 32'd5, 32'd0, 1'b0);
        chk("dz_hi", hiOut, 32'h11);
        chk("dz_lo", loOut, 32'h22);

        // mthi / mtlo / mflo
        do_mt(5'd7, 32'hDEAD_BEEF);
        do_mt(5'd8, 32'h1234);
        drive(1'b1, 5'd6, 32'd0, 32'd0, 1'b0);
        chk("mflo_val", mdResult, 32'h1234);
        chk("mflo_hiout", hiOut, 32'hDEAD_BEEF);
        chk("mflo_busy", {31'd0, busy}, 32'd0);

        // eValid=0 suppresses start
        drive(1'b0, 5'd2, 32'd3, 32'd3, 1'b1);
        chk("inval_start", {31'd0, start}, 32'd0);
        chk("inval_stall", {31'd0, stallReq}, 32'd0);
        @(posedge clk); #1;
        chk("inval_busy", {31'd0, busy}, 32'd0);
        chk("inval_lo", loOut, m_lo);

        // Asynchronous reset in the middle of a divide
        drive(1'b1, 5'd4, 32'd1000, 32'd3, 1'b0);
        @(posedge clk); #1;
        eValid = 1'b0; hiloCtrl = 5'd0;
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy_pre", {31'd0, busy}, 32'd1);
        reset = 1'b1; #1;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_hi", hiOut, 32'd0);
        chk("arst_lo", loOut, 32'd0);
        @(negedge clk); reset = 1'b0;
        do_op(5'd1, 32'd3, 32'd4, 1'b0);
        chk("multu_lo", loOut, 32'd12);
        chk("multu_hi", hiOut, 32'd0);

`ifdef MDU_MADD_EN
        do_mt(5'd7, 32'd0);
        do_mt(5'd8, 32'd5);
        do_op(5'd9, 32'd2, 32'd3, 1'b1);
        chk("madd_lo", loOut, 32'd11);
        chk("madd_hi", hiOut, 32'd0);
`else
        drive(1'b1, 5'd9, 32'd2, 32'd3, 1'b1);
        chk("c9_start", {31'd0, start}, 32'd0);
        chk("c9_stall", {31'd0, stallReq}, 32'd0);
        chk("c9_mdres", mdResult, 32'd0);
        @(posedge clk); #1;
        eValid = 1'b0; hiloCtrl = 5'd0; dUsesHilo = 1'b0;
        chk("c9_busy", {31'd0, busy}, 32'd0);
        chk("c9_hi", hiOut, m_hi);
        chk("c9_lo", loOut, m_lo);
`endif

        // Random operations against the model
        for (int k = 0; k < 24; k++) begin
            rc = 5'($urandom_range(1, 4));
            ra = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (k % 6 == 5) do_mt(5'($urandom_range(7, 8)), $urandom);
            do_op(rc, ra, rb, 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
